// File: rtl/jpeg_bsp_pkg.sv
// Shared types and constants for the JPEG byte stuffer: FSM states, FIFO entry
// layout and the marker bytes.
package jpeg_bsp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_STUFF,
        S_EOI_FF,
        S_EOI_D9,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nbytes;
        logic        last;
    } entry_t;

    localparam logic [7:0] MARK_FF  = 8'hFF;
    localparam logic [7:0] STUFF_00 = 8'h00;
    localparam logic [7:0] EOI_LO   = 8'hD9;

    // Whole bytes needed to hold cnt MSB-aligned residual bits.
    function automatic logic [2:0] eof_nbytes(input logic [4:0] cnt);
        return 3'((6'(cnt) + 6'd7) >> 3);
    endfunction

    // Everything below the residual bits becomes 1 so the last byte is 1-padded.
    function automatic logic [31:0] eof_fill(input logic [31:0] b, input logic [4:0] cnt);
        return b | (32'hFFFF_FFFF >> cnt);
    endfunction

endpackage

// File: rtl/bsp_word_fifo.sv
// Synchronous FIFO of entropy-word entries; a pop in the same cycle frees a
// slot for a write arriving at full occupancy.
module bsp_word_fifo
    import jpeg_bsp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  entry_t                        wr_data,
    input  logic                          rd_en,
    output entry_t                        rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    entry_t         mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_wr;
    logic           do_rd;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Serialises 32-bit entropy words MSB-first into bytes with 0xFF/0x00 stuffing,
// 1-padding of the final byte and an optional EOI marker.
module jpeg_byte_stuffer
    import jpeg_bsp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter bit EMIT_EOI   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bits,
    input  logic        rdy,
    input  logic [4:0]  eof_cnt,
    input  logic        eof_p,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_addr,
    output logic [23:0] frame_size,
    output logic        done,
    output logic        overflow
);

    localparam state_t AFTER_LAST = EMIT_EOI ? S_EOI_FF : S_FIN;

    state_t      state, next;
    entry_t      wr_entry, rd_entry;
    logic        wr_req, pop, accept;
    logic        full, empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic [31:0] shreg;
    logic [2:0]  rem;
    logic        last_q;
    logic        unused_fifo;

    assign unused_fifo = ^count;
    assign wr_req      = rdy || eof_p;

    always_comb begin
        wr_entry.data   = bits;
        wr_entry.nbytes = 3'd4;
        wr_entry.last   = eof_p;
        if (eof_p && !rdy) begin
            wr_entry.data   = eof_fill(bits, eof_cnt);
            wr_entry.nbytes = eof_nbytes(eof_cnt);
        end
    end

    bsp_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        out_valid = 1'b0;
        out_byte  = 8'h00;
        case (state)
            S_DATA:   begin out_valid = 1'b1; out_byte = shreg[31:24]; end
            S_STUFF:  begin out_valid = 1'b1; out_byte = STUFF_00;     end
            S_EOI_FF: begin out_valid = 1'b1; out_byte = MARK_FF;      end
            S_EOI_D9: begin out_valid = 1'b1; out_byte = EOI_LO;       end
            default:  ;
        endcase
    end

    assign accept = out_valid && out_ready;
    assign done   = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        pop  = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop = 1'b1;
                if (rd_entry.nbytes != 3'd0) next = S_DATA;
                else if (rd_entry.last)      next = AFTER_LAST;
            end
            // rem still counts the byte on display here; in STUFF it has
            // already been decremented for the 0xFF that preceded it.
            S_DATA: if (out_ready) begin
                if (shreg[31:24] == MARK_FF) next = S_STUFF;
                else if (rem != 3'd1)        next = S_DATA;
                else if (last_q)             next = AFTER_LAST;
                else                         next = S_IDLE;
            end
            S_STUFF: if (out_ready) begin
                if (rem != 3'd0) next = S_DATA;
                else if (last_q) next = AFTER_LAST;
                else             next = S_IDLE;
            end
            S_EOI_FF: if (out_ready) next = S_EOI_D9;
            S_EOI_D9: if (out_ready) next = S_FIN;
            S_FIN:    next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            rem        <= '0;
            last_q     <= 1'b0;
            out_addr   <= '0;
            frame_size <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                shreg  <= rd_entry.data;
                rem    <= rd_entry.nbytes;
                last_q <= rd_entry.last;
            end
            if (state == S_DATA && out_ready) begin
                shreg <= shreg << 8;
                rem   <= rem - 3'd1;
            end
            if (state == S_FIN)  out_addr <= '0;
            else if (accept)     out_addr <= out_addr + 24'd1;
            // Latch the size on the way into FIN so it is already valid while done pulses.
            if (state != S_FIN && next == S_FIN)
                frame_size <= out_addr + {23'd0, accept};
            if (wr_req && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: streams, stuffing, padding, backpressure,
// overflow and mid-frame reset, with hand-computed expected bytes.
module tb_jpeg_byte_stuffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bits;
    logic        rdy;
    logic [4:0]  eof_cnt;
    logic        eof_p;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_addr;
    logic [23:0] frame_size;
    logic        done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  got_b[$];
    logic [23:0] got_a[$];
    int          done_cnt = 0;
    logic [23:0] fs_at_done = '0;

    always #5 clk = ~clk;

    jpeg_byte_stuffer #(.FIFO_DEPTH(8), .EMIT_EOI(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bits       (bits),
        .rdy        (rdy),
        .eof_cnt    (eof_cnt),
        .eof_p      (eof_p),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .frame_size (frame_size),
        .done       (done),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_b.push_back(out_byte);
            got_a.push_back(out_addr);
        end
        if (done) begin
            done_cnt++;
            fs_at_done = frame_size;
        end
    end

    // Called at posedge+1; holds the write for one edge, returns at posedge+1.
    task automatic send(input logic [31:0] b, input logic r, input logic e, input logic [4:0] c);
        bits = b; rdy = r; eof_p = e; eof_cnt = c;
        @(posedge clk); #1;
        rdy = 1'b0; eof_p = 1'b0;
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt > start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got %h exp 00", out_byte); end
        checks++; if (out_addr !== 24'd0) begin failures++; $display("FAIL reset_addr got %0d exp 0", out_addr); end
        checks++; if (frame_size !== 24'd0) begin failures++; $display("FAIL reset_fsize got %0d exp 0", frame_size); end
        checks++; if (done !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got done=%b ovf=%b exp 0 0", done, overflow); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_b[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hD9};
        bit ok;
        int d0;
        align();
        got_b.delete(); got_a.delete(); d0 = done_cnt;
        out_ready = 1'b1;
        send(32'h1234_5678, 1'b1, 1'b0, 5'd0);
        // cycle N+1: eof written now, first byte not yet visible
        bits = 32'h0; eof_p = 1'b1; eof_cnt = 5'd0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_n1 got valid=%b exp 0", out_valid); end
        @(posedge clk); #1;
        eof_p = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'h12) begin failures++; $display("FAIL latency_n2 got valid=%b byte=%h exp 1 12", out_valid, out_byte); end
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got no done exp done"); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != d0 + 1) begin failures++; $display("FAIL basic_done_count got %0d exp %0d", done_cnt - d0, 1); end
        checks++; if (fs_at_done !== 24'd6) begin failures++; $display("FAIL basic_fsize got %0d exp 6", fs_at_done); end
        checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL basic_len got %0d exp %0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL basic_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp_b[i], i);
            end
        end
    endtask

    task automatic test_stuffing();
        logic [7:0] exp_b[$] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB, 8'hFF, 8'hD9};
        bit ok;
        align();
        got_b.delete(); got_a.delete();
        send(32'hFF00_FFAB, 1'b1, 1'b0, 5'd0);
        send(32'h0, 1'b0, 1'b1, 5'd0);
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stuff_timeout got no done exp done"); end
        checks++; if (fs_at_done !== 24'd8) begin failures++; $display("FAIL stuff_fsize got %0d exp 8", fs_at_done); end
        checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL stuff_len got %0d exp %0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL stuff_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp_b[i], i);
            end
        end
    endtask

    task automatic test_partial();
        logic [7:0] exp1[$] = '{8'hBF, 8'hFF, 8'hD9};
        logic [7:0] exp2[$] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hD9};
        bit ok;
        align();
        got_b.delete(); got_a.delete();
        send(32'hA000_0000, 1'b0, 1'b1, 5'd3);
        wait_done(100, ok);
        checks++; if (!ok || fs_at_done !== 24'd3) begin failures++; $display("FAIL partial3_fsize got %0d ok=%0d exp 3", fs_at_done, ok); end
        checks++; if (got_b.size() != exp1.size()) begin failures++; $display("FAIL partial3_len got %0d exp %0d", got_b.size(), exp1.size()); end
        for (int i = 0; i < exp1.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp1[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL partial3_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp1[i], i);
            end
        end
        align();
        got_b.delete(); got_a.delete();
        send(32'hFF80_0000, 1'b0, 1'b1, 5'd9);
        wait_done(100, ok);
        checks++; if (!ok || fs_at_done !== 24'd6) begin failures++; $display("FAIL partial9_fsize got %0d ok=%0d exp 6", fs_at_done, ok); end
        checks++; if (got_b.size() != exp2.size()) begin failures++; $display("FAIL partial9_len got %0d exp %0d", got_b.size(), exp2.size()); end
        for (int i = 0; i < exp2.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp2[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL partial9_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp2[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[$] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hFF, 8'hD9};
        logic [7:0]  hb;
        logic [23:0] ha;
        bit ok;
        bit seen;
        align();
        got_b.delete(); got_a.delete();
        send(32'hA1B2_C3D4, 1'b1, 1'b0, 5'd0);
        send(32'h0, 1'b0, 1'b1, 5'd0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid && out_addr == 24'd2) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL bp_reach got no addr2 exp addr2"); end
        out_ready = 1'b0;
        hb = out_byte; ha = out_addr;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_byte !== 8'hC3 || out_addr !== 24'd2 || out_byte !== hb || out_addr !== ha) begin
                failures++; $display("FAIL bp_hold got %b %h@%0d exp 1 c3@2", out_valid, out_byte, out_addr);
            end
        end
        out_ready = 1'b1;
        wait_done(100, ok);
        checks++; if (!ok || fs_at_done !== 24'd6) begin failures++; $display("FAIL bp_fsize got %0d ok=%0d exp 6", fs_at_done, ok); end
        checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL bp_len got %0d exp %0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL bp_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp_b[i], i);
            end
        end
    endtask

    // Word 0 sits in the shift register, words 1..8 fill the FIFO, word 9 is dropped.
    task automatic test_overflow();
        logic [31:0] w;
        bit ok;
        align();
        got_b.delete(); got_a.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
            send(w, 1'b1, 1'b0, 5'd0);
            if (k == 8) begin
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got %b exp 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 200 && got_b.size() < 36; i++) begin @(posedge clk); #1; end
        send(32'h0, 1'b0, 1'b1, 5'd0);
        wait_done(200, ok);
        checks++; if (!ok || fs_at_done !== 24'd38) begin failures++; $display("FAIL ovf_fsize got %0d ok=%0d exp 38", fs_at_done, ok); end
        checks++; if (got_b.size() != 38) begin failures++; $display("FAIL ovf_len got %0d exp 38", got_b.size()); end
        for (int i = 0; i < 36 && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== 8'(i+1) || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL ovf_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], 8'(i+1), i);
            end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b[$] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'hFF, 8'hD9};
        bit ok;
        align();
        got_b.delete(); got_a.delete();
        out_ready = 1'b0;
        send(32'hAABB_CCDD, 1'b1, 1'b0, 5'd0);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'hAA) begin failures++; $display("FAIL rmid_data got %b %h exp 1 aa", out_valid, out_byte); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 24'd0 || frame_size !== 24'd0 || overflow !== 1'b0 || out_byte !== 8'h00) begin
            failures++; $display("FAIL rmid_clear got v=%b a=%0d fs=%0d ovf=%b b=%h exp 0 0 0 0 00", out_valid, out_addr, frame_size, overflow, out_byte);
        end
        out_ready = 1'b1;
        send(32'h5566_7788, 1'b1, 1'b0, 5'd0);
        send(32'h0, 1'b0, 1'b1, 5'd0);
        wait_done(100, ok);
        checks++; if (!ok || fs_at_done !== 24'd6) begin failures++; $display("FAIL rmid_fsize got %0d ok=%0d exp 6", fs_at_done, ok); end
        checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL rmid_len got %0d exp %0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL rmid_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp_b[i], i);
            end
        end
    endtask

    task automatic test_rdy_and_eof();
        logic [7:0] exp_b[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hD9};
        bit ok;
        align();
        got_b.delete(); got_a.delete();
        send(32'h1122_3344, 1'b1, 1'b1, 5'd12);
        wait_done(100, ok);
        checks++; if (!ok || fs_at_done !== 24'd6) begin failures++; $display("FAIL both_fsize got %0d ok=%0d exp 6", fs_at_done, ok); end
        checks++; if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL both_len got %0d exp %0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i] || got_a[i] !== 24'(i)) begin
                failures++; $display("FAIL both_byte%0d got %h@%0d exp %h@%0d", i, got_b[i], got_a[i], exp_b[i], i);
            end
        end
    endtask

    initial begin
        bits = '0; rdy = 1'b0; eof_p = 1'b0; eof_cnt = '0; out_ready = 1'b1; rst = 1'b1;
        test_reset();
        test_basic();
        test_stuffing();
        test_partial();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_rdy_and_eof();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
